// File: rtl/nco_iq_demod_pkg.sv
// Shared definitions for the NCO I/Q demodulator: FSM encoding and accumulator sizing.
package nco_iq_demod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_ACC  = 2'd2
  } state_e;

  // Accumulator width sized so a full-length window of extreme products cannot wrap.
  function automatic int acc_width(input int adw, input int mpr, input int cw);
    return adw + mpr + cw;
  endfunction

endpackage

// File: rtl/nco_demod_mac.sv
// One demodulator channel: registered full-precision product, boxcar accumulator,
// round-half-up arithmetic shift and saturation into the output register.
module nco_demod_mac
  import nco_iq_demod_pkg::*;
#(
  parameter int adw = 14,
  parameter int mpr = 14,
  parameter int cw  = 16,
  parameter int ow  = 32,
  parameter int osh = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cap,
  input  logic                  add,
  input  logic                  done,
  input  logic                  clr,
  input  logic signed [adw-1:0] smp,
  input  logic signed [mpr-1:0] coef,
  output logic signed [ow-1:0]  res,
  output logic                  sat
);

  localparam int PW = adw + mpr;
  localparam int AW = acc_width(adw, mpr, cw);
  localparam int RW = AW + 1;

  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] sum;
  logic signed [RW-1:0] rnd;
  logic signed [ow-1:0] res_q, res_d;
  logic signed [ow-1:0] clamp;

  assign sum = acc_q + $signed({{(AW-PW){prod_q[PW-1]}}, prod_q});

  // One spare bit above the accumulator keeps the rounding add from wrapping.
  if (osh == 0) begin : g_no_round
    assign rnd = {sum[AW-1], sum};
  end else begin : g_round
    localparam logic [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (osh - 1);
    assign rnd = ($signed({sum[AW-1], sum}) + $signed(HALF)) >>> osh;
  end

  always_comb begin
    sat   = ~((&rnd[RW-1:ow-1]) | ~(|rnd[RW-1:ow-1]));
    clamp = rnd[ow-1:0];
    if (sat) begin
      clamp = rnd[RW-1] ? {1'b1, {(ow-1){1'b0}}} : {1'b0, {(ow-1){1'b1}}};
    end

    prod_d = prod_q;
    if (cap) begin
      prod_d = $signed({{(PW-adw){smp[adw-1]}}, smp}) * $signed({{(PW-mpr){coef[mpr-1]}}, coef});
    end

    acc_d = acc_q;
    if (done || clr) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = sum;
    end

    res_d = done ? clamp : res_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: rtl/nco_iq_demod.sv
// Quadrature demodulator: window FSM, accepted-sample counter and sticky overflow,
// driving one MAC channel per phase (I with cosine, Q with sine).
module nco_iq_demod
  import nco_iq_demod_pkg::*;
#(
  parameter int adw = 14,
  parameter int mpr = 14,
  parameter int cw  = 16,
  parameter int ow  = 32,
  parameter int osh = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  cont,
  input  logic [cw-1:0]         win_len,
  input  logic signed [adw-1:0] adc_data,
  input  logic                  adc_valid,
  input  logic                  nco_valid,
  input  logic signed [mpr-1:0] fsin_i,
  input  logic signed [mpr-1:0] fcos_i,
  output logic signed [ow-1:0]  i_out,
  output logic signed [ow-1:0]  q_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  ovf,
  output state_e                dbg_state
);

  // Handshake: a sample is taken on a clken cycle with adc_valid and nco_valid both
  // high while ARM/ACC; there is no backpressure. out_valid is a one-enabled-cycle
  // pulse with no ready; it holds with the registers while clken is low.

  state_e        state_q, state_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [cw-1:0] win_q, win_d;
  logic          prod_v_q, prod_v_d;
  logic          prod_last_q, prod_last_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;

  logic start_ok, accept, last, add, done, clr;
  logic sat_i, sat_q;

  always_comb begin
    start_ok = clken & start & ~stop & (state_q == ST_IDLE);
    accept   = clken & ~stop & adc_valid & nco_valid & ((state_q == ST_ARM) || (state_q == ST_ACC));
    last     = accept & (cnt_q == win_q - cw'(1));
    add      = clken & ~stop & prod_v_q;
    done     = add & prod_last_q;
    clr      = clken & (stop | start_ok);

    state_d = state_q;
    if (clken) begin
      if (stop) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (start) state_d = ST_ARM;
          ST_ARM:  if (nco_valid) state_d = (last && !cont) ? ST_IDLE : ST_ACC;
          ST_ACC:  if (last && !cont) state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end

    win_d = win_q;
    if (start_ok) begin
      win_d = (win_len == '0) ? cw'(1) : win_len;
    end

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = last ? '0 : cnt_q + cw'(1);
    end

    // The completing product is still in flight after the FSM has left ACC.
    prod_v_d    = clken ? accept : prod_v_q;
    prod_last_d = clken ? last : prod_last_q;
    out_valid_d = clken ? done : out_valid_q;
    busy_d      = (state_d != ST_IDLE);
    ovf_d       = (start_ok ? 1'b0 : ovf_q) | (done & (sat_i | sat_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      win_q       <= cw'(1);
      prod_v_q    <= 1'b0;
      prod_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      prod_v_q    <= prod_v_d;
      prod_last_q <= prod_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  nco_demod_mac #(.adw(adw), .mpr(mpr), .cw(cw), .ow(ow), .osh(osh)) u_mac_i (
    .clk   (clk),
    .reset (reset),
    .cap   (accept),
    .add   (add),
    .done  (done),
    .clr   (clr),
    .smp   (adc_data),
    .coef  (fcos_i),
    .res   (i_out),
    .sat   (sat_i)
  );

  nco_demod_mac #(.adw(adw), .mpr(mpr), .cw(cw), .ow(ow), .osh(osh)) u_mac_q (
    .clk   (clk),
    .reset (reset),
    .cap   (accept),
    .add   (add),
    .done  (done),
    .clr   (clr),
    .smp   (adc_data),
    .coef  (fsin_i),
    .res   (q_out),
    .sat   (sat_q)
  );

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nco_iq_demod.sv
// Bench for nco_iq_demod: two instances (shift 0 and shift 2) share all stimulus;
// expected I/Q for both are queued when a window is driven and popped on out_valid.
module tb_nco_iq_demod;
  import nco_iq_demod_pkg::*;

  localparam int W = 128;

  logic               clk = 1'b0;
  logic               reset;
  logic               clken, start, stop, cont;
  logic [15:0]        win_len;
  logic signed [13:0] adc_data;
  logic               adc_valid, nco_valid;
  logic signed [13:0] fsin_i, fcos_i;

  logic signed [31:0] i0, q0, i2, q2;
  logic               ov0, ov2, busy0, busy2, ovf0, ovf2;
  state_e             st0, st2;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nco_iq_demod #(.adw(14), .mpr(14), .cw(16), .ow(32), .osh(0)) dut0 (
    .clk(clk), .reset(reset), .clken(clken), .start(start), .stop(stop), .cont(cont),
    .win_len(win_len), .adc_data(adc_data), .adc_valid(adc_valid), .nco_valid(nco_valid),
    .fsin_i(fsin_i), .fcos_i(fcos_i), .i_out(i0), .q_out(q0), .out_valid(ov0),
    .busy(busy0), .ovf(ovf0), .dbg_state(st0)
  );

  nco_iq_demod #(.adw(14), .mpr(14), .cw(16), .ow(32), .osh(2)) dut2 (
    .clk(clk), .reset(reset), .clken(clken), .start(start), .stop(stop), .cont(cont),
    .win_len(win_len), .adc_data(adc_data), .adc_valid(adc_valid), .nco_valid(nco_valid),
    .fsin_i(fsin_i), .fcos_i(fcos_i), .i_out(i2), .q_out(q2), .out_valid(ov2),
    .busy(busy2), .ovf(ovf2), .dbg_state(st2)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_val(input longint s, input int sh);
    longint r;
    r = (sh == 0) ? s : ((s + (longint'(1) <<< (sh - 1))) >>> sh);
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    else if (r < -64'sd2147483648) r = -64'sd2147483648;
    return r[31:0];
  endfunction

  task automatic push_exp(input longint si, input longint sq);
    exp_q.push_back({exp_val(si, 0), exp_val(sq, 0), exp_val(si, 2), exp_val(sq, 2)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_smp(input int a, input int fc, input int fs, input bit av, input bit nv);
    adc_data  = 14'(a);
    fcos_i    = 14'(fc);
    fsin_i    = 14'(fs);
    adc_valid = av;
    nco_valid = nv;
  endtask

  task automatic start_win(input int wl, input bit c);
    cont    = c;
    win_len = 16'(wl);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic one_shot(input int wl, input int a, input int fc, input int fs, input int n);
    start_win(wl, 1'b0);
    for (int k = 0; k < n; k++) begin
      set_smp(a, fc, fs, 1'b1, 1'b1);
      tick();
    end
    set_smp(0, 0, 0, 1'b0, 1'b1);
    repeat (3) tick();
  endtask

  // Scoreboard: every enabled out_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && clken && ov0) begin
      if (exp_q.size() == 0) begin
        check("extra_out_valid", longint'(ov0), 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("i_out_sh0", longint'(i0), longint'($signed(exp_e[127:96])));
        check("q_out_sh0", longint'(q0), longint'($signed(exp_e[95:64])));
        check("i_out_sh2", longint'(i2), longint'($signed(exp_e[63:32])));
        check("q_out_sh2", longint'(q2), longint'($signed(exp_e[31:0])));
      end
      check("out_valid_sh2", longint'(ov2), longint'(ov0));
    end
  end

  initial begin
    reset = 1'b1; clken = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; win_len = '0;
    set_smp(0, 0, 0, 1'b0, 1'b0);
    #1;
    check("rst_i_out", longint'(i0), 0);
    check("rst_q_out", longint'(q0), 0);
    check("rst_out_valid", longint'(ov0), 0);
    check("rst_busy", longint'(busy0), 0);
    check("rst_ovf", longint'(ovf0), 0);
    check("rst_state", longint'(st0), longint'(ST_IDLE));
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // DC window with latency and busy checks
    push_exp(64'sd400 * 64'sd8191, 0);
    start_win(4, 1'b0);
    at_neg();
    check("dc_busy_arm", longint'(busy0), 1);
    check("dc_state_arm", longint'(st0), longint'(ST_ARM));
    for (int k = 0; k < 4; k++) begin
      set_smp(100, 8191, 0, 1'b1, 1'b1);
      tick();
    end
    set_smp(0, 0, 0, 1'b0, 1'b1);
    at_neg();
    check("dc_lat_t1", longint'(ov0), 0);
    check("dc_busy_fall", longint'(busy0), 0);
    tick();
    at_neg();
    check("dc_lat_t2", longint'(ov0), 1);
    tick();
    at_neg();
    check("dc_single_pulse", longint'(ov0), 0);
    check("dc_sb_empty", longint'(exp_q.size()), 0);
    tick();

    // Saturation over a full-length window
    push_exp(64'sd65535 * 64'sd67108864, 64'sd65535 * 64'sd8192);
    start_win(65535, 1'b0);
    set_smp(-8192, -8192, -1, 1'b1, 1'b1);
    repeat (65535) tick();
    set_smp(0, 0, 0, 1'b0, 1'b1);
    repeat (5) tick();
    at_neg();
    check("sat_ovf_sh0", longint'(ovf0), 1);
    check("sat_ovf_sh2", longint'(ovf2), 1);
    check("sat_sb_empty", longint'(exp_q.size()), 0);
    tick();

    // Continuous mode, two back-to-back windows of two samples
    push_exp(3, 6);
    push_exp(7, 14);
    start_win(2, 1'b1);
    at_neg();
    check("cont_ovf_cleared", longint'(ovf0), 0);
    for (int k = 1; k <= 4; k++) begin
      set_smp(k, 1, 2, 1'b1, 1'b1);
      tick();
    end
    set_smp(0, 0, 0, 1'b0, 1'b1);
    repeat (3) tick();
    at_neg();
    check("cont_still_acc", longint'(st0), longint'(ST_ACC));
    cont = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    at_neg();
    check("cont_stop_idle", longint'(st0), longint'(ST_IDLE));
    check("cont_sb_empty", longint'(exp_q.size()), 0);
    tick();

    // Rounding, positive and negative half cases
    push_exp(6, -3);
    one_shot(1, 3, 2, -1, 1);
    push_exp(-6, 3);
    one_shot(1, -3, 2, -1, 1);
    check("rnd_sb_empty", longint'(exp_q.size()), 0);

    // win_len of zero behaves as one
    push_exp(35, -15);
    one_shot(0, 5, 7, -3, 1);
    check("wl0_sb_empty", longint'(exp_q.size()), 0);
    check("wl0_busy", longint'(busy0), 0);

    // start while busy is ignored
    push_exp(300, 100);
    start_win(4, 1'b0);
    set_smp(10, 3, 1, 1'b1, 1'b1); tick();
    set_smp(20, 3, 1, 1'b1, 1'b1); tick();
    set_smp(30, 3, 1, 1'b1, 1'b1);
    win_len = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    set_smp(40, 3, 1, 1'b1, 1'b1); tick();
    set_smp(0, 0, 0, 1'b0, 1'b1);
    repeat (3) tick();
    check("busy_start_sb_empty", longint'(exp_q.size()), 0);

    // stop after two of four samples discards the window
    start_win(4, 1'b0);
    set_smp(50, 5, 5, 1'b1, 1'b1); tick();
    set_smp(60, 5, 5, 1'b1, 1'b1); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    at_neg();
    check("stop_state", longint'(st0), longint'(ST_IDLE));
    check("stop_busy", longint'(busy0), 0);
    repeat (4) tick();
    check("stop_sb_empty", longint'(exp_q.size()), 0);

    // nco_valid low keeps the FSM armed
    push_exp(14, 63);
    start_win(1, 1'b0);
    set_smp(7, 2, 9, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("arm_hold", longint'(st0), longint'(ST_ARM));
      tick();
    end
    nco_valid = 1'b1;
    tick();
    set_smp(0, 0, 0, 1'b0, 1'b1);
    repeat (3) tick();
    check("arm_sb_empty", longint'(exp_q.size()), 0);

    // clken gaps and adc_valid gaps give the gapless result
    push_exp(2200, -1100);
    start_win(3, 1'b0);
    set_smp(11, 100, -50, 1'b1, 1'b1); tick();
    set_smp(0, 0, 0, 1'b0, 1'b1); tick();
    clken = 1'b0;
    set_smp(999, 100, -50, 1'b1, 1'b1);
    repeat (5) tick();
    clken = 1'b1;
    set_smp(-22, 100, -50, 1'b1, 1'b1); tick();
    set_smp(0, 0, 0, 1'b0, 1'b1); tick();
    set_smp(33, 100, -50, 1'b1, 1'b1); tick();
    set_smp(0, 0, 0, 1'b0, 1'b1); tick();
    clken = 1'b0;
    at_neg();
    check("clken_ov_hold_a", longint'(ov0), 1);
    tick();
    at_neg();
    check("clken_ov_hold_b", longint'(ov0), 1);
    tick();
    clken = 1'b1;
    tick();
    at_neg();
    check("clken_ov_clear", longint'(ov0), 0);
    check("clken_sb_empty", longint'(exp_q.size()), 0);
    check("clken_ovf", longint'(ovf0), 0);
    tick();

    // Asynchronous reset mid-window
    start_win(4, 1'b0);
    set_smp(70, 9, 4, 1'b1, 1'b1); tick();
    tick();
    reset = 1'b1;
    #1;
    check("arst_i_out", longint'(i0), 0);
    check("arst_q_out", longint'(q0), 0);
    check("arst_busy", longint'(busy0), 0);
    check("arst_state", longint'(st0), longint'(ST_IDLE));
    tick();
    reset = 1'b0;
    repeat (6) tick();
    at_neg();
    check("arst_idle_after", longint'(st0), longint'(ST_IDLE));
    check("arst_sb_empty", longint'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
